mem_dma: RTL and testbench



---
 rtl/mem_dma.sv | 158 +++++++++++++++
 tb/tb_mem_dma.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_dma.sv
// mem_dma: block-transfer engine for a single-port synchronous memory.
// COPY moves LEN words from SRC to DST, reading one word and then writing it
// (two cycles per word). FILL writes a captured constant to LEN words at DST
// (one cycle per word). Pointers wrap modulo 2**AW. Memory-side outputs are
// decoded from the state so that an asynchronous reset silences the port at once.
module mem_dma #(
  parameter int AW = 10,
  parameter int DW = 8,
  parameter int LW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          mode,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [LW-1:0] len,
  input  logic [DW-1:0] fill,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          mem_ena,
  output logic          mem_wen,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdt,
  input  logic [DW-1:0] mem_rdt
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_WR   = 3'd2;
  localparam logic [2:0] S_FILL = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]    state_reg;
  logic [2:0]    state_next;
  logic [AW-1:0] src_ptr_reg;
  logic [AW-1:0] dst_ptr_reg;
  logic [LW-1:0] cnt_reg;
  logic [DW-1:0] fill_reg;
  logic          last_word;

  // The word being written now is the final one of the transfer.
  assign last_word = (cnt_reg == LW'(1));

  // Next-state selection; abort only matters while a transfer is active.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          if (len == '0)
            state_next = S_DONE;
          else if (mode)
            state_next = S_FILL;
          else
            state_next = S_RD;
        end
      end
      S_RD: begin
        state_next = abort ? S_IDLE : S_WR;
      end
      S_WR: begin
        if (abort)
          state_next = S_IDLE;
        else if (last_word)
          state_next = S_DONE;
        else
          state_next = S_RD;
      end
      S_FILL: begin
        if (abort)
          state_next = S_IDLE;
        else if (last_word)
          state_next = S_DONE;
        else
          state_next = S_FILL;
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State plus transfer context: captured on an accepted start, stepped per write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      src_ptr_reg <= '0;
      dst_ptr_reg <= '0;
      cnt_reg     <= '0;
      fill_reg    <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            src_ptr_reg <= src;
            dst_ptr_reg <= dst;
            cnt_reg     <= len;
            fill_reg    <= fill;
          end
        end
        S_WR: begin
          src_ptr_reg <= src_ptr_reg + AW'(1);
          dst_ptr_reg <= dst_ptr_reg + AW'(1);
          cnt_reg     <= cnt_reg - LW'(1);
        end
        S_FILL: begin
          dst_ptr_reg <= dst_ptr_reg + AW'(1);
          cnt_reg     <= cnt_reg - LW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Memory port and status decode; idle port drives all zeros.
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    mem_ena = 1'b0;
    mem_wen = 1'b0;
    mem_adr = '0;
    mem_wdt = '0;
    case (state_reg)
      S_RD: begin
        busy    = 1'b1;
        mem_ena = 1'b1;
        mem_adr = src_ptr_reg;
      end
      S_WR: begin
        busy    = 1'b1;
        mem_ena = 1'b1;
        mem_wen = 1'b1;
        mem_adr = dst_ptr_reg;
        mem_wdt = mem_rdt;
      end
      S_FILL: begin
        busy    = 1'b1;
        mem_ena = 1'b1;
        mem_wen = 1'b1;
        mem_adr = dst_ptr_reg;
        mem_wdt = fill_reg;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mem_dma.sv
// tb_mem_dma: self-checking bench for mem_dma with a behavioural memory,
// a word-level reference memory, directed vectors and random transfers.
module tb_mem_dma;

  localparam int AW    = 10;
  localparam int DW    = 8;
  localparam int LW    = AW + 1;
  localparam int DEPTH = 1 << AW;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          mode  = 1'b0;
  logic [AW-1:0] src   = '0;
  logic [AW-1:0] dst   = '0;
  logic [LW-1:0] len   = '0;
  logic [DW-1:0] fill  = '0;
  logic          abort = 1'b0;
  logic          busy;
  logic          done;
  logic          mem_ena;
  logic          mem_wen;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wdt;
  logic [DW-1:0] mem_rdt;

  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];

  logic          pl_en  = 1'b0;
  logic [AW-1:0] pl_adr = '0;
  logic [DW-1:0] pl_dat = '0;

  int n_pass   = 0;
  int n_total  = 0;
  int prot_err = 0;

  typedef struct {
    logic          m;
    logic [AW-1:0] s;
    logic [AW-1:0] d;
    logic [LW-1:0] l;
    logic [DW-1:0] f;
    int            e_done;
    int            e_rd;
    int            e_wr;
    int            e_busy;
  } vec_t;

  vec_t tbl [7];

  mem_dma #(.AW(AW), .DW(DW), .LW(LW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .mode    (mode),
    .src     (src),
    .dst     (dst),
    .len     (len),
    .fill    (fill),
    .abort   (abort),
    .busy    (busy),
    .done    (done),
    .mem_ena (mem_ena),
    .mem_wen (mem_wen),
    .mem_adr (mem_adr),
    .mem_wdt (mem_wdt),
    .mem_rdt (mem_rdt)
  );

  always #5 clk = ~clk;

  // Single-port synchronous memory with one-cycle read latency and a preload port.
  always @(posedge clk) begin
    if (pl_en)
      mem[pl_adr] <= pl_dat;
    else if (mem_ena && mem_wen)
      mem[mem_adr] <= mem_wdt;
    if (mem_ena && !mem_wen)
      mem_rdt <= mem[mem_adr];
  end

  // Port rules that must hold in every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_wen && !mem_ena) prot_err++;
      if (!mem_wen && mem_wdt != '0) prot_err++;
      if (!mem_ena && mem_adr != '0) prot_err++;
      if (busy != mem_ena) prot_err++;
      if (done && busy) prot_err++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic load_word(input logic [AW-1:0] a, input logic [DW-1:0] v);
    @(negedge clk);
    pl_en  = 1'b1;
    pl_adr = a;
    pl_dat = v;
    ref_mem[a] = v;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Reference effect of n words of a transfer, ascending addresses with wrap.
  task automatic model_xfer(input logic m, input logic [AW-1:0] s,
                            input logic [AW-1:0] d, input int n,
                            input logic [DW-1:0] f);
    for (int i = 0; i < n; i++) begin
      logic [AW-1:0] sa;
      logic [AW-1:0] da;
      sa = s + AW'(i);
      da = d + AW'(i);
      ref_mem[da] = m ? f : ref_mem[sa];
    end
  endtask

  task automatic check_mem(input string name);
    int bad;
    bad = 0;
    for (int a = 0; a < DEPTH; a++)
      if (mem[a] !== ref_mem[a]) bad++;
    check(name, bad, 0);
  endtask

  // Issue one request and observe until done; dk=0 means the cycle budget ran out.
  task automatic run(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                     input logic [LW-1:0] l, input logic [DW-1:0] f,
                     output int dk, output int rd, output int wr, output int bz);
    @(negedge clk);
    mode = m; src = s; dst = d; len = l; fill = f; start = 1'b1;
    dk = 0; rd = 0; wr = 0; bz = 0;
    for (int k = 1; k <= 3000; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (mem_ena && !mem_wen) rd++;
      if (mem_ena && mem_wen) wr++;
      if (busy) bz++;
      if (done) begin
        dk = k;
        break;
      end
    end
    @(negedge clk);
    check("done_one_cycle", int'(done), 0);
  endtask

  task automatic xfer_checked(input string tag, input logic m, input logic [AW-1:0] s,
                              input logic [AW-1:0] d, input logic [LW-1:0] l,
                              input logic [DW-1:0] f, input int e_done, input int e_rd,
                              input int e_wr, input int e_busy);
    int dk, rd, wr, bz;
    run(m, s, d, l, f, dk, rd, wr, bz);
    $display("xfer %s mode=%0d src=%h dst=%h len=%0d fill=%h -> done@%0d rd=%0d wr=%0d busy=%0d",
             tag, m, s, d, l, f, dk, rd, wr, bz);
    check({tag, "_done_cycle"}, dk, e_done);
    check({tag, "_reads"}, rd, e_rd);
    check({tag, "_writes"}, wr, e_wr);
    check({tag, "_busy_cycles"}, bz, e_busy);
    model_xfer(m, s, d, int'(l), f);
    check_mem({tag, "_memory"});
  endtask

  initial begin
    int rd, wr, dk, k2, seen_done;
    logic [8*8-1:0] exp_copy;

    // Directed vectors: hand-computed cycle counts.
    tbl[0] = '{1'b0, 10'h010, 10'h100, 11'd4,    8'h00, 9,    4, 4,    8};
    tbl[1] = '{1'b1, 10'h000, 10'h3FE, 11'd4,    8'hA5, 5,    0, 4,    4};
    tbl[2] = '{1'b0, 10'h123, 10'h234, 11'd0,    8'h00, 1,    0, 0,    0};
    tbl[3] = '{1'b1, 10'h000, 10'h200, 11'd1,    8'h3C, 2,    0, 1,    1};
    tbl[4] = '{1'b0, 10'h3FF, 10'h050, 11'd2,    8'h00, 5,    2, 2,    4};
    tbl[5] = '{1'b0, 10'h300, 10'h302, 11'd5,    8'h00, 11,   5, 5,    10};
    tbl[6] = '{1'b1, 10'h000, 10'h155, 11'd1024, 8'h99, 1025, 0, 1024, 1024};

    // Random preload while held in reset.
    for (int a = 0; a < DEPTH; a++) begin
      @(negedge clk);
      pl_en  = 1'b1;
      pl_adr = AW'(a);
      pl_dat = DW'($urandom);
      ref_mem[a] = pl_dat;
    end
    @(negedge clk);
    pl_en = 1'b0;

    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_mem_ena", int'(mem_ena), 0);
    check("reset_mem_wen", int'(mem_wen), 0);
    check("reset_mem_adr", int'(mem_adr), 0);
    check("reset_mem_wdt", int'(mem_wdt), 0);
    rst_n = 1'b1;

    load_word(10'h010, 8'd11);
    load_word(10'h011, 8'd22);
    load_word(10'h012, 8'd33);
    load_word(10'h013, 8'd44);

    for (int i = 0; i < 7; i++) begin
      xfer_checked($sformatf("vec%0d", i), tbl[i].m, tbl[i].s, tbl[i].d, tbl[i].l,
                   tbl[i].f, tbl[i].e_done, tbl[i].e_rd, tbl[i].e_wr, tbl[i].e_busy);
      if (i == 0) begin
        check("copy_word0", int'(mem[10'h100]), 11);
        check("copy_word1", int'(mem[10'h101]), 22);
        check("copy_word2", int'(mem[10'h102]), 33);
        check("copy_word3", int'(mem[10'h103]), 44);
      end
      if (i == 1) begin
        check("fill_3fe", int'(mem[10'h3FE]), 'hA5);
        check("fill_3ff", int'(mem[10'h3FF]), 'hA5);
        check("fill_000", int'(mem[10'h000]), 'hA5);
        check("fill_001", int'(mem[10'h001]), 'hA5);
      end
    end

    // COPY len=8 with an ignored start in cycle 3 and abort during the fourth read.
    @(negedge clk);
    mode = 1'b0; src = 10'h020; dst = 10'h120; len = 11'd8; fill = 8'h00; start = 1'b1;
    rd = 0; wr = 0; seen_done = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (mem_ena && !mem_wen) rd++;
      if (mem_ena && mem_wen) wr++;
      if (done) seen_done++;
      if (k == 8) check("abort_idle_next", int'(busy), 0);
      start = (k == 3);
      abort = (k == 7);
      if (k == 3) begin
        mode = 1'b1; dst = 10'h180; len = 11'd3; fill = 8'hEE;
      end
    end
    $display("xfer abort: rd=%0d wr=%0d done_pulses=%0d", rd, wr, seen_done);
    check("abort_reads", rd, 4);
    check("abort_writes", wr, 3);
    check("abort_no_done", seen_done, 0);
    model_xfer(1'b0, 10'h020, 10'h120, 3, 8'h00);
    check_mem("abort_memory");

    // Asynchronous reset in the middle of a FILL.
    @(negedge clk);
    mode = 1'b1; dst = 10'h240; len = 11'd20; fill = 8'h5A; start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    $display("xfer reset_mid_fill: busy=%0d ena=%0d wen=%0d", busy, mem_ena, mem_wen);
    check("rst_async_busy", int'(busy), 0);
    check("rst_async_ena", int'(mem_ena), 0);
    check("rst_async_wen", int'(mem_wen), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_xfer(1'b1, 10'h000, 10'h240, 5, 8'h5A);
    check_mem("rst_memory");
    xfer_checked("after_rst", 1'b1, 10'h000, 10'h245, 11'd3, 8'hC3, 4, 0, 3, 3);

    // Back-to-back: start held from the DONE cycle into the following IDLE cycle.
    @(negedge clk);
    mode = 1'b0; src = 10'h060; dst = 10'h160; len = 11'd2; fill = 8'h00; start = 1'b1;
    dk = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        dk = k;
        break;
      end
    end
    check("b2b_first_done", dk, 5);
    mode = 1'b1; dst = 10'h1C0; len = 11'd2; fill = 8'h77; start = 1'b1;
    @(negedge clk);
    check("b2b_start_in_done_ignored", int'(busy), 0);
    k2 = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        k2 = k;
        break;
      end
    end
    $display("xfer back_to_back: first done@%0d second done@%0d", dk, k2);
    check("b2b_second_done", k2, 3);
    model_xfer(1'b0, 10'h060, 10'h160, 2, 8'h00);
    model_xfer(1'b1, 10'h000, 10'h1C0, 2, 8'h77);
    check_mem("b2b_memory");

    // Random transfers against the reference rules.
    for (int t = 0; t < 25; t++) begin
      logic          m;
      logic [AW-1:0] s, d;
      logic [LW-1:0] l;
      logic [DW-1:0] f;
      int            n;
      m = 1'($urandom_range(0, 1));
      s = AW'($urandom_range(0, DEPTH - 1));
      d = AW'($urandom_range(0, DEPTH - 1));
      l = LW'($urandom_range(0, 40));
      f = DW'($urandom);
      n = int'(l);
      xfer_checked($sformatf("rnd%0d", t), m, s, d, l, f,
                   (n == 0) ? 1 : (m ? n + 1 : 2 * n + 1),
                   m ? 0 : n, n, m ? n : 2 * n);
    end

    check("port_protocol_violations", prot_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
